nois_system_nios2_qsys_0_oci_dct_ctrl: RTL and testbench

//  Packs 2-bit trace atoms from the Nios II OCI into a 30-bit dct_buffer.

---
 rtl/nois_system_nios2_qsys_0_oci_dct_ctrl.sv | 154 +++++++++++++++
 tb/tb_nois_system_nios2_qsys_0_oci_dct_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nois_system_nios2_qsys_0_oci_dct_ctrl.sv
// Packs 2-bit OCI trace atoms into a 30-bit word and hands full or flushed
// words to the trace store; exposes the live buffer/count and an overflow flag.
module nois_system_nios2_qsys_0_oci_dct_ctrl #(
  parameter int ATOM_W         = 2,
  parameter int ATOMS_PER_WORD = 15,
  parameter int BUF_W          = ATOM_W * ATOMS_PER_WORD,
  parameter int CNT_W          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  output logic              atom_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and data is held while valid & !ready.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ATOMS_PER_WORD);

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   dct_buffer_q, dct_buffer_d;
  logic [CNT_W-1:0]   dct_count_q, dct_count_d;
  logic               out_valid_q, out_valid_d;
  logic [BUF_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               overflow_q, overflow_d;
  logic               flush_done_q, flush_done_d;

  logic slot_free;
  logic buf_full;
  logic buf_busy;
  logic accept;
  logic transfer;
  logic drop;

  always_comb begin
    state_d      = state_q;
    dct_buffer_d = dct_buffer_q;
    dct_count_d  = dct_count_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    overflow_d   = overflow_q;
    flush_done_d = 1'b0;
    atom_ready   = 1'b0;

    slot_free = !out_valid_q || out_ready;
    buf_full  = (dct_count_q == FULL_CNT);
    buf_busy  = (dct_count_q != '0);

    case (state_q)
      S_IDLE: begin
        if (trace_en) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        atom_ready = !buf_full || slot_free;
        if (flush || !trace_en) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!buf_busy && !out_valid_q) begin
          flush_done_d = 1'b1;
          state_d      = trace_en ? S_COLLECT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    accept   = atom_valid && atom_ready;
    drop     = (state_q == S_COLLECT) && atom_valid && !atom_ready;
    transfer = slot_free && (buf_full || ((state_q == S_FLUSH) && buf_busy));

    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = dct_buffer_q;
      out_count_d = dct_count_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // An atom accepted on the transfer edge starts the next word at bit 0.
    if (transfer) begin
      dct_buffer_d = '0;
      dct_count_d  = '0;
      if (accept) begin
        dct_buffer_d[ATOM_W-1:0] = atom;
        dct_count_d              = CNT_W'(1);
      end
    end else if (accept) begin
      for (int k = 0; k < ATOMS_PER_WORD; k++) begin
        if (dct_count_q == CNT_W'(k)) dct_buffer_d[k*ATOM_W +: ATOM_W] = atom;
      end
      dct_count_d = dct_count_q + CNT_W'(1);
    end

    if (state_q == S_IDLE) begin
      dct_buffer_d = '0;
      dct_count_d  = '0;
    end

    if (drop) overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dct_buffer_q <= '0;
      dct_count_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      overflow_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dct_buffer_q <= dct_buffer_d;
      dct_count_q  <= dct_count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      overflow_q   <= overflow_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign dct_buffer = dct_buffer_q;
  assign dct_count  = dct_count_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_count  = out_count_q;
  assign overflow   = overflow_q;
  assign flush_done = flush_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_nois_system_nios2_qsys_0_oci_dct_ctrl.sv
// Directed bench for the trace atom packer: expected words are queued as
// stimulus is driven and compared when the consumer takes them.
module tb_nois_system_nios2_qsys_0_oci_dct_ctrl;

  logic        clk;
  logic        reset;
  logic        trace_en;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_data;
  logic [3:0]  out_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        clr_overflow;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [29:0] exp_data_q[$];
  logic [3:0]  exp_cnt_q[$];

  localparam logic [1:0] ST_IDLE = 2'd0, ST_COLLECT = 2'd1;

  nois_system_nios2_qsys_0_oci_dct_ctrl dut (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .atom_valid(atom_valid), .atom(atom), .atom_ready(atom_ready),
    .flush(flush), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .overflow(overflow), .clr_overflow(clr_overflow),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard
  task automatic push_exp(input logic [29:0] d, input logic [3:0] c);
    exp_data_q.push_back(d);
    exp_cnt_q.push_back(c);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      chk("mon_word_expected", 32'(exp_data_q.size() != 0), 32'd1);
      if (exp_data_q.size() != 0) begin
        chk("mon_data", 32'(out_data), 32'(exp_data_q.pop_front()));
        chk("mon_count", 32'(out_count), 32'(exp_cnt_q.pop_front()));
      end
    end
  end

  // drivers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] a, input logic exp_rdy, input string tag);
    atom_valid = 1'b1;
    atom       = a;
    @(negedge clk);
    chk(tag, 32'(atom_ready), 32'(exp_rdy));
    cyc();
    atom_valid = 1'b0;
  endtask

  task automatic wait_flush_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
      cyc();
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse_1cyc"}, 32'(flush_done), 32'd0);
    cyc();
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wait_flush_done(tag);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60 && exp_data_q.size() != 0; n++) cyc();
    cyc();
    chk(tag, 32'(exp_data_q.size()), 32'd0);
  endtask

  initial begin
    logic [29:0] w1, w2;

    reset = 1'b1; trace_en = 1'b0; atom_valid = 1'b0; atom = 2'd0;
    flush = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_atom_ready", 32'(atom_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_atom_ready", 32'(atom_ready), 32'd0);

    // 1: fifteen atoms of 01 form one full word
    trace_en = 1'b1; out_ready = 1'b1;
    cyc();
    chk("t1_state_collect", 32'(dbg_state), 32'(ST_COLLECT));
    push_exp(30'h15555555, 4'd15);
    for (int i = 0; i < 15; i++) offer(2'b01, 1'b1, "t1_rdy");
    chk("t1_cnt_full", 32'(dct_count), 32'd15);
    chk("t1_buf_full", 32'(dct_buffer), 32'h15555555);
    cyc();
    chk("t1_cnt_wrap", 32'(dct_count), 32'd0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    drain("t1_drain");

    // 2: partial word via flush
    push_exp(30'h1B, 4'd3);
    offer(2'd3, 1'b1, "t2_rdy");
    offer(2'd2, 1'b1, "t2_rdy");
    offer(2'd1, 1'b1, "t2_rdy");
    chk("t2_buf", 32'(dct_buffer), 32'h1B);
    do_flush("t2_flush_done");
    chk("t2_taken_before_done", 32'(exp_data_q.size()), 32'd0);
    chk("t2_state_collect", 32'(dbg_state), 32'(ST_COLLECT));
    chk("t2_cnt", 32'(dct_count), 32'd0);

    // 3: blocked consumer, 31 atoms, last one dropped
    out_ready = 1'b0;
    w1 = '0; w2 = '0;
    for (int k = 0; k < 15; k++) begin
      w1[2*k +: 2] = 2'(k);
      w2[2*k +: 2] = 2'(k + 15);
    end
    push_exp(w1, 4'd15);
    push_exp(w2, 4'd15);
    for (int i = 0; i < 31; i++) offer(2'(i), 1'(i < 30), "t3_rdy");
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_cnt_full", 32'(dct_count), 32'd15);
    chk("t3_buf_unchanged", 32'(dct_buffer), 32'(w2));
    chk("t3_atom_ready_low", 32'(atom_ready), 32'd0);
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    cyc();
    chk("t3_hold_data", 32'(out_data), 32'(w1));
    chk("t3_hold_count", 32'(out_count), 32'd15);
    out_ready = 1'b1;
    drain("t3_drain");
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    chk("t3_overflow_clr", 32'(overflow), 32'd0);

    // 4: accept on the transfer edge
    push_exp(30'h2AAAAAAA, 4'd15);
    for (int i = 0; i < 15; i++) offer(2'b10, 1'b1, "t4_rdy");
    offer(2'b11, 1'b1, "t4_rdy16");
    chk("t4_out_valid", 32'(out_valid), 32'd1);
    chk("t4_out_count", 32'(out_count), 32'd15);
    chk("t4_out_data", 32'(out_data), 32'h2AAAAAAA);
    chk("t4_dct_count", 32'(dct_count), 32'd1);
    chk("t4_dct_buffer", 32'(dct_buffer), 32'h3);
    push_exp(30'h3, 4'd1);
    do_flush("t4_flush_done");
    chk("t4_drained", 32'(exp_data_q.size()), 32'd0);

    // 5: asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 22; i++) offer(2'(i), 1'b1, "t5_rdy");
    chk("t5_cnt7", 32'(dct_count), 32'd7);
    chk("t5_out_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_out_valid", 32'(out_valid), 32'd0);
    chk("t5_async_out_data", 32'(out_data), 32'd0);
    chk("t5_async_out_count", 32'(out_count), 32'd0);
    chk("t5_async_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("t5_async_dct_count", 32'(dct_count), 32'd0);
    chk("t5_async_state", 32'(dbg_state), 32'(ST_IDLE));
    cyc();
    reset = 1'b0;
    cyc();
    push_exp(30'hB, 4'd2);
    offer(2'd3, 1'b1, "t5_rdy_new");
    offer(2'd2, 1'b1, "t5_rdy_new");
    out_ready = 1'b1;
    do_flush("t5_flush_done");
    chk("t5_drained", 32'(exp_data_q.size()), 32'd0);

    // 6: overflow set beats clear
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) offer(2'b01, 1'b1, "t6_rdy");
    chk("t6_overflow_idle", 32'(overflow), 32'd0);
    offer(2'b00, 1'b0, "t6_drop1");
    chk("t6_overflow_set", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    offer(2'b00, 1'b0, "t6_drop2");
    clr_overflow = 1'b0;
    chk("t6_set_wins", 32'(overflow), 32'd1);
    chk("t6_buf_unchanged", 32'(dct_buffer), 32'h15555555);
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    chk("t6_clr_alone", 32'(overflow), 32'd0);
    push_exp(30'h15555555, 4'd15);
    push_exp(30'h15555555, 4'd15);
    out_ready = 1'b1;
    drain("t6_drain");
    trace_en = 1'b0;
    cyc();
    wait_flush_done("t6_flush_done");
    chk("t6_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_buf_zero", 32'(dct_buffer), 32'd0);
    chk("end_queue_empty", 32'(exp_data_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
